alu: RTL and testbench



---
 rtl/alu.sv | 70 +++++++
 tb/tb_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// rtl/alu.sv - registered two-operand add/and unit with carry and zero flags
module alu #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             sel,
  output logic [WIDTH-1:0] zout,
  output logic             carry,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] next_z;
  logic             next_carry;

  // Bitwise ripple-carry adder: each sum bit depends only on its own operand
  // bits and the incoming carry, so known low bits stay known even when
  // higher operand bits are unknown (a vector '+' would smear X everywhere).
  always_comb begin
    logic [WIDTH:0] c;
    c       = '0;
    add_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = ain[i] ^ bin[i] ^ c[i];
      c[i+1]     = (ain[i] & bin[i]) | (c[i] & (ain[i] ^ bin[i]));
    end
    add_carry = c[WIDTH];
  end

  // Bitwise AND path; carry is forced low for this operation.
  always_comb begin
    and_res = ain & bin;
  end

  // Operation select feeding the output registers.
  always_comb begin
    next_z     = add_sum;
    next_carry = add_carry;
    if (sel) begin
      next_z     = and_res;
      next_carry = 1'b0;
    end
  end

  // Output registers: reset clears everything, idle cycles hold the last
  // result and flags, and out_valid pulses once per accepted operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      zout      <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        zout  <= next_z;
        carry <= next_carry;
        zero  <= ~|next_z;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed vector bench for alu (WIDTH=2 and WIDTH=8)
module tb_alu;

  typedef struct {
    logic       sel;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] z;
    logic       c;
    logic       zr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] ain;
  logic [1:0] bin;
  logic       sel;
  logic [1:0] zout;
  logic       carry;
  logic       zero;
  logic       out_valid;

  logic       in_valid8;
  logic [7:0] ain8;
  logic [7:0] bin8;
  logic       sel8;
  logic [7:0] zout8;
  logic       carry8;
  logic       zero8;
  logic       out_valid8;

  int n_checks;
  int n_fail;

  vec_t sweep[$];
  vec_t alt[$];

  alu #(.WIDTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ain(ain), .bin(bin), .sel(sel),
    .zout(zout), .carry(carry), .zero(zero), .out_valid(out_valid)
  );

  alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .ain(ain8), .bin(bin8), .sel(sel8),
    .zout(zout8), .carry(carry8), .zero(zero8), .out_valid(out_valid8)
  );

  // free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(ref vec_t q[$], input logic s, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] z,
                         input logic c, input logic zr);
    vec_t v;
    v.sel = s; v.a = a; v.b = b; v.z = z; v.c = c; v.zr = zr;
    q.push_back(v);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    in_valid = 1'b1;
    sel      = v.sel;
    ain      = v.a;
    bin      = v.b;
    tick();
    chk({tag, " zout"},  {30'd0, zout}, {30'd0, v.z});
    chk({tag, " carry"}, {31'd0, carry}, {31'd0, v.c});
    chk({tag, " zero"},  {31'd0, zero}, {31'd0, v.zr});
    chk({tag, " valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // sel, a, b, expected zout, carry, zero
    add_vec(sweep, 1'b0, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0);
    add_vec(sweep, 1'b0, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0);
    add_vec(sweep, 1'b0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
    add_vec(sweep, 1'b0, 2'd3, 2'd2, 2'd1, 1'b1, 1'b0);
    add_vec(sweep, 1'b0, 2'd3, 2'd3, 2'd2, 1'b1, 1'b0);
    add_vec(sweep, 1'b0, 2'd3, 2'd1, 2'd0, 1'b1, 1'b1);
    add_vec(sweep, 1'b0, 2'd1, 2'd3, 2'd0, 1'b1, 1'b1);
    add_vec(sweep, 1'b1, 2'd3, 2'd2, 2'd2, 1'b0, 1'b0);
    add_vec(sweep, 1'b1, 2'd1, 2'd2, 2'd0, 1'b0, 1'b1);
    add_vec(sweep, 1'b1, 2'd1, 2'd3, 2'd1, 1'b0, 1'b0);
    add_vec(sweep, 1'b1, 2'd2, 2'd1, 2'd0, 1'b0, 1'b1);

    add_vec(alt, 1'b0, 2'd2, 2'd2, 2'd0, 1'b1, 1'b1);
    add_vec(alt, 1'b1, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
    add_vec(alt, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    add_vec(alt, 1'b1, 2'd2, 2'd3, 2'd2, 1'b0, 1'b0);
    add_vec(alt, 1'b0, 2'd2, 2'd1, 2'd3, 1'b0, 1'b0);
    add_vec(alt, 1'b1, 2'd0, 2'd3, 2'd0, 1'b0, 1'b1);

    // reset held two cycles with a live operation on the inputs
    rst       = 1'b1;
    in_valid  = 1'b1;
    ain       = 2'd3;
    bin       = 2'd3;
    sel       = 1'b0;
    in_valid8 = 1'b0;
    ain8      = 8'd0;
    bin8      = 8'd0;
    sel8      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset zout",  {30'd0, zout}, 32'd0);
      chk("reset carry", {31'd0, carry}, 32'd0);
      chk("reset zero",  {31'd0, zero}, 32'd0);
      chk("reset valid", {31'd0, out_valid}, 32'd0);
    end
    chk("reset valid8", {31'd0, out_valid8}, 32'd0);

    // first operation after release appears one cycle later
    rst = 1'b0;
    tick();
    chk("first zout",  {30'd0, zout}, 32'd2);
    chk("first carry", {31'd0, carry}, 32'd1);
    chk("first valid", {31'd0, out_valid}, 32'd1);

    // add and and sweeps, back to back
    for (int i = 0; i < sweep.size(); i++) run_vec($sformatf("sweep%0d", i), sweep[i]);

    // hold: one add then three idle cycles with changing operands
    in_valid = 1'b1; sel = 1'b0; ain = 2'd3; bin = 2'd2;
    tick();
    chk("hold issue zout",  {30'd0, zout}, 32'd1);
    chk("hold issue carry", {31'd0, carry}, 32'd1);
    chk("hold issue valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ain = 2'(i);
      bin = 2'(3 - i);
      sel = 1'(i);
      tick();
      chk($sformatf("hold%0d zout", i),  {30'd0, zout}, 32'd1);
      chk($sformatf("hold%0d carry", i), {31'd0, carry}, 32'd1);
      chk($sformatf("hold%0d zero", i),  {31'd0, zero}, 32'd0);
      chk($sformatf("hold%0d valid", i), {31'd0, out_valid}, 32'd0);
    end

    // alternating select every cycle
    for (int i = 0; i < alt.size(); i++) run_vec($sformatf("alt%0d", i), alt[i]);

    // reset coinciding with an operation discards it
    in_valid = 1'b1; sel = 1'b0; ain = 2'd1; bin = 2'd1; rst = 1'b1;
    tick();
    chk("midrst valid", {31'd0, out_valid}, 32'd0);
    chk("midrst zout",  {30'd0, zout}, 32'd0);
    chk("midrst carry", {31'd0, carry}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("postrst valid", {31'd0, out_valid}, 32'd0);
    chk("postrst zout",  {30'd0, zout}, 32'd0);

    // unknown high operand bits must not corrupt the known low sum bit
    in_valid = 1'b1; sel = 1'b0; ain = 2'bx0; bin = 2'bx1;
    tick();
    chk("xprop zout0", {31'd0, zout[0]}, 32'd1);
    chk("xprop valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0; ain = 2'd0; bin = 2'd0;

    // 8-bit instance: 200 + 100 wraps to 44 with carry
    in_valid8 = 1'b1; sel8 = 1'b0; ain8 = 8'd200; bin8 = 8'd100;
    tick();
    chk("w8 zout",  {24'd0, zout8}, 32'd44);
    chk("w8 carry", {31'd0, carry8}, 32'd1);
    chk("w8 zero",  {31'd0, zero8}, 32'd0);
    chk("w8 valid", {31'd0, out_valid8}, 32'd1);
    in_valid8 = 1'b0;
    tick();
    chk("w8 idle valid", {31'd0, out_valid8}, 32'd0);
    chk("w8 idle zout",  {24'd0, zout8}, 32'd44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
